// File: rtl/rc6_pkg.sv
// Shared definitions for the RC6 core: FSM states, width-generic rotates and key-index helpers.
package rc6_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_POST, ST_DONE} state_e;

  localparam int unsigned MAX_W = 64;

  // Rotates act on the low w bits of a MAX_W container; n must be below w.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input logic [6:0] n,
                                            input int unsigned w);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] xm;
    m  = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    xm = x & m;
    return ((xm << n) | (xm >> (w - 32'(n)))) & m;
  endfunction

  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x, input logic [6:0] n,
                                            input int unsigned w);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] xm;
    m  = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    xm = x & m;
    return ((xm >> n) | (xm << (w - 32'(n)))) & m;
  endfunction

  function automatic int unsigned key_even(input int unsigned i);
    return 2 * i;
  endfunction

  function automatic int unsigned key_odd(input int unsigned i);
    return 2 * i + 1;
  endfunction

endpackage

// File: rtl/rc6_round.sv
// One combinational RC6 round: decryption always, encryption added when RC6_ENC_EN is defined.
module rc6_round
  import rc6_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] k0_i,
  input  logic [W-1:0] k1_i,
`ifdef RC6_ENC_EN
  input  logic         enc_i,
`endif
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] c_o,
  output logic [W-1:0] d_o
);

  localparam int LGW = $clog2(W);

  function automatic logic [W-1:0] rl(input logic [W-1:0] x, input logic [LGW-1:0] n);
    return W'(rotl(MAX_W'(x), 7'(n), W));
  endfunction

  function automatic logic [W-1:0] rr(input logic [W-1:0] x, input logic [LGW-1:0] n);
    return W'(rotr(MAX_W'(x), 7'(n), W));
  endfunction

  function automatic logic [W-1:0] mix(input logic [W-1:0] x);
    return rl(x * ((x << 1) + W'(1)), LGW'(LGW));
  endfunction

  logic [W-1:0] t_dec, u_dec, a_dec, c_dec;

  // After the word rotation D is the incoming C and B is the incoming A.
  always_comb begin
    u_dec = mix(c_i);
    t_dec = mix(a_i);
    c_dec = rr(b_i - k1_i, t_dec[LGW-1:0]) ^ u_dec;
    a_dec = rr(d_i - k0_i, u_dec[LGW-1:0]) ^ t_dec;
  end

`ifdef RC6_ENC_EN
  logic [W-1:0] t_enc, u_enc, a_enc, c_enc;

  always_comb begin
    t_enc = mix(b_i);
    u_enc = mix(d_i);
    a_enc = rl(a_i ^ t_enc, u_enc[LGW-1:0]) + k0_i;
    c_enc = rl(c_i ^ u_enc, t_enc[LGW-1:0]) + k1_i;
  end

  assign a_o = enc_i ? b_i   : a_dec;
  assign b_o = enc_i ? c_enc : a_i;
  assign c_o = enc_i ? d_i   : c_dec;
  assign d_o = enc_i ? a_enc : c_i;
`else
  assign a_o = a_dec;
  assign b_o = a_i;
  assign c_o = c_dec;
  assign d_o = c_i;
`endif

endmodule

// File: rtl/rc6_decrypt_core.sv
// Iterative RC6 block engine, one round per clock. Defining RC6_ENC_EN adds a mode port
// (1 = encrypt) sampled with each accepted block.
module rc6_decrypt_core
  import rc6_pkg::*;
#(
  parameter int W = 32,
  parameter int R = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [W-1:0]           in_c,
  input  logic [W-1:0]           in_d,
  input  logic [(2*R+4)*W-1:0]   key_s,
`ifdef RC6_ENC_EN
  input  logic                   mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_a,
  output logic [W-1:0]           out_b,
  output logic [W-1:0]           out_c,
  output logic [W-1:0]           out_d,
  output logic                   busy
);

  localparam int NK  = 2 * R + 4;
  localparam int KIW = $clog2(NK);
  localparam int CW  = $clog2(R + 1);

  logic [W-1:0] s_arr [NK];

  generate
    for (genvar gi = 0; gi < NK; gi++) begin : g_key
      assign s_arr[gi] = key_s[gi*W +: W];
    end
  endgenerate

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, b_q, c_q, d_q;
  logic [W-1:0]  a_d, b_d, c_d, d_d;
  logic          enc_q, enc_d;
  logic          in_enc;
  int unsigned   rnd_idx;
  logic [W-1:0]  k0, k1;
  logic [W-1:0]  ra, rb, rc, rd;

`ifdef RC6_ENC_EN
  assign in_enc = mode;
`else
  assign in_enc = 1'b0;
`endif

  // The counter always runs R..1; encryption walks the key table upward instead.
  always_comb begin
    rnd_idx = enc_q ? (32'(R) + 32'd1 - 32'(cnt_q)) : 32'(cnt_q);
  end

  assign k0 = s_arr[KIW'(key_even(rnd_idx))];
  assign k1 = s_arr[KIW'(key_odd(rnd_idx))];

  rc6_round #(.W(W)) u_round (
    .a_i  (a_q),
    .b_i  (b_q),
    .c_i  (c_q),
    .d_i  (d_q),
    .k0_i (k0),
    .k1_i (k1),
`ifdef RC6_ENC_EN
    .enc_i(enc_q),
`endif
    .a_o  (ra),
    .b_o  (rb),
    .c_o  (rc),
    .d_o  (rd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          enc_d   = in_enc;
          cnt_d   = CW'(R);
          state_d = ST_ROUND;
          if (in_enc) begin
            a_d = in_a;
            b_d = in_b + s_arr[0];
            c_d = in_c;
            d_d = in_d + s_arr[1];
          end else begin
            a_d = in_a - s_arr[NK-2];
            b_d = in_b;
            c_d = in_c - s_arr[NK-1];
            d_d = in_d;
          end
        end
      end
      ST_ROUND: begin
        a_d   = ra;
        b_d   = rb;
        c_d   = rc;
        d_d   = rd;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_POST;
      end
      ST_POST: begin
        state_d = ST_DONE;
        if (enc_q) begin
          a_d = a_q + s_arr[NK-2];
          c_d = c_q + s_arr[NK-1];
        end else begin
          b_d = b_q - s_arr[0];
          d_d = d_q - s_arr[1];
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      enc_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign out_d     = d_q;

endmodule

// File: tb/tb_rc6_decrypt_core.sv
// Bench for rc6_decrypt_core: a W=32/R=20 instance and a W=16/R=4 instance, both checked
// against a loop-level RC6 model; encrypt-mode steps are built only with RC6_ENC_EN.
module tb_rc6_decrypt_core;

  typedef logic [63:0] karr_t [44];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic sel = 1'b0;
`ifdef RC6_ENC_EN
  logic mode = 1'b0;
`endif
  logic [31:0] ia = '0, ib = '0, ic = '0, id = '0;
  logic [44*32-1:0] key32 = '0;
  logic [12*16-1:0] key16 = '0;

  logic        in_ready32, out_valid32, busy32;
  logic [31:0] oa32, ob32, oc32, od32;
  logic        in_ready16, out_valid16, busy16;
  logic [15:0] oa16, ob16, oc16, od16;

  logic         cur_ready, cur_valid, cur_busy;
  logic [127:0] cur_out;
  assign cur_ready = sel ? in_ready16 : in_ready32;
  assign cur_valid = sel ? out_valid16 : out_valid32;
  assign cur_busy  = sel ? busy16 : busy32;
  assign cur_out   = sel ? {16'h0, oa16, 16'h0, ob16, 16'h0, oc16, 16'h0, od16}
                         : {oa32, ob32, oc32, od32};

  rc6_decrypt_core #(.W(32), .R(20)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_ready32),
    .in_a(ia), .in_b(ib), .in_c(ic), .in_d(id), .key_s(key32),
`ifdef RC6_ENC_EN
    .mode(mode),
`endif
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_a(oa32), .out_b(ob32), .out_c(oc32), .out_d(od32), .busy(busy32)
  );

  rc6_decrypt_core #(.W(16), .R(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_ready16),
    .in_a(ia[15:0]), .in_b(ib[15:0]), .in_c(ic[15:0]), .in_d(id[15:0]), .key_s(key16),
`ifdef RC6_ENC_EN
    .mode(mode),
`endif
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_a(oa16), .out_b(ob16), .out_c(oc16), .out_d(od16), .busy(busy16)
  );

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, lat = 0, c1 = 0;
  karr_t k32, k16;
  logic [63:0] lk [4];
  logic [63:0] sa, sb;
  int si, sj;
  logic [31:0] x [4];
  logic [127:0] exp_out, exp2;

  task automatic chk(input string tag, input bit ok, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotl_w(input logic [63:0] x, input int n, input int w);
    logic [63:0] m, xm;
    int s;
    m  = (64'd1 << w) - 64'd1;
    xm = x & m;
    s  = n % w;
    return ((xm << s) & m) | (xm >> (w - s));
  endfunction

  function automatic logic [63:0] rotr_w(input logic [63:0] x, input int n, input int w);
    return rotl_w(x, (w - (n % w)) % w, w);
  endfunction

  function automatic logic [127:0] ref_dec(input int w, input int r, input karr_t k,
                                           input logic [31:0] a, b, c, d);
    logic [63:0] m, aa, bb, cc, dd, tmp, t, u;
    int lg;
    lg = $clog2(w);
    m  = (64'd1 << w) - 64'd1;
    aa = (a - k[2*r+2]) & m;
    bb = b & m;
    cc = (c - k[2*r+3]) & m;
    dd = d & m;
    for (int i = r; i >= 1; i--) begin
      tmp = dd; dd = cc; cc = bb; bb = aa; aa = tmp;
      u  = rotl_w((dd * (2 * dd + 1)) & m, lg, w);
      t  = rotl_w((bb * (2 * bb + 1)) & m, lg, w);
      cc = rotr_w((cc - k[2*i+1]) & m, int'(t % 64'(w)), w) ^ u;
      aa = rotr_w((aa - k[2*i]) & m, int'(u % 64'(w)), w) ^ t;
    end
    bb = (bb - k[0]) & m;
    dd = (dd - k[1]) & m;
    return {aa[31:0], bb[31:0], cc[31:0], dd[31:0]};
  endfunction

`ifdef RC6_ENC_EN
  function automatic logic [127:0] ref_enc(input int w, input int r, input karr_t k,
                                           input logic [31:0] a, b, c, d);
    logic [63:0] m, aa, bb, cc, dd, tmp, t, u;
    int lg;
    lg = $clog2(w);
    m  = (64'd1 << w) - 64'd1;
    aa = a & m;
    bb = (b + k[0]) & m;
    cc = c & m;
    dd = (d + k[1]) & m;
    for (int i = 1; i <= r; i++) begin
      t  = rotl_w((bb * (2 * bb + 1)) & m, lg, w);
      u  = rotl_w((dd * (2 * dd + 1)) & m, lg, w);
      aa = (rotl_w(aa ^ t, int'(u % 64'(w)), w) + k[2*i]) & m;
      cc = (rotl_w(cc ^ u, int'(t % 64'(w)), w) + k[2*i+1]) & m;
      tmp = aa; aa = bb; bb = cc; cc = dd; dd = tmp;
    end
    aa = (aa + k[2*r+2]) & m;
    cc = (cc + k[2*r+3]) & m;
    return {aa[31:0], bb[31:0], cc[31:0], dd[31:0]};
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pack_keys();
    for (int j = 0; j < 44; j++) key32[j*32 +: 32] = k32[j][31:0];
    for (int j = 0; j < 12; j++) key16[j*16 +: 16] = k16[j][15:0];
  endtask

  task automatic accept_block(input logic [31:0] a, b, c, d, input bit drop);
    int n;
    ia = a; ib = b; ic = c; id = d;
    in_valid = 1'b1;
    n = 0;
    while (!cur_ready && n < 100) begin tick(); n++; end
    chk("in_ready_wait", cur_ready === 1'b1, cur_ready, 1'b1);
    tick();
    acc_cyc = cyc;
    if (drop) in_valid = 1'b0;
  endtask

  // lat = index of the first out_valid cycle, counting the handshake cycle as 0.
  task automatic wait_out(input int exp_lat, input logic [127:0] exp);
    int n;
    n = 0;
    while (!cur_valid && n < 400) begin tick(); n++; end
    chk("out_valid_wait", cur_valid === 1'b1, cur_valid, 1'b1);
    lat = cyc - acc_cyc + 1;
    chk("latency", lat == exp_lat, lat, exp_lat);
    chk("result", cur_out === exp, cur_out, exp);
    $display("txn sel=%0d in=%h %h %h %h out=%h exp=%h lat=%0d",
             sel, ia, ib, ic, id, cur_out, exp, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // S table from the all-zero 128-bit key, W=32, R=20.
    k32[0] = 64'hB7E1_5163;
    for (int i = 1; i < 44; i++) k32[i] = (k32[i-1] + 64'h9E37_79B9) & 64'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) lk[i] = '0;
    sa = '0; sb = '0; si = 0; sj = 0;
    for (int s = 0; s < 132; s++) begin
      k32[si] = rotl_w(k32[si] + sa + sb, 3, 32);
      sa = k32[si];
      lk[sj] = rotl_w(lk[sj] + sa + sb, int'((sa + sb) % 64'd32), 32);
      sb = lk[sj];
      si = (si + 1) % 44;
      sj = (sj + 1) % 4;
    end
    for (int j = 0; j < 44; j++) k16[j] = (j < 12) ? 64'($urandom_range(0, 65535)) : 64'd0;
    pack_keys();

    // Reset state on both instances.
    tick(); tick();
    rst = 1'b0;
    exp_out = '0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      chk("rst_out_valid", cur_valid === 1'b0, cur_valid, 1'b0);
      chk("rst_busy", cur_busy === 1'b0, cur_busy, 1'b0);
      chk("rst_in_ready", cur_ready === 1'b1, cur_ready, 1'b1);
      chk("rst_outputs", cur_out === exp_out, cur_out, exp_out);
    end
    sel = 1'b0;
    tick();

    // Known answer, out_ready high: DONE lasts one cycle.
    accept_block(32'h36a5c38f, 32'h78f7b156, 32'h4edf29c1, 32'h1ea44898, 1'b1);
    wait_out(22, exp_out);
    tick();
    chk("done_one_cycle_ready", cur_ready === 1'b1, cur_ready, 1'b1);
    chk("done_one_cycle_valid", cur_valid === 1'b0, cur_valid, 1'b0);

    // Backpressure: result and handshake held while out_ready is low.
    out_ready = 1'b0;
    accept_block(32'h36a5c38f, 32'h78f7b156, 32'h4edf29c1, 32'h1ea44898, 1'b1);
    wait_out(22, exp_out);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", cur_valid === 1'b1, cur_valid, 1'b1);
      chk("bp_in_ready", cur_ready === 1'b0, cur_ready, 1'b0);
      chk("bp_outputs", cur_out === exp_out, cur_out, exp_out);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", cur_ready === 1'b1, cur_ready, 1'b1);
    chk("bp_release_valid", cur_valid === 1'b0, cur_valid, 1'b0);

    // Back-to-back with in_valid held high throughout.
    for (int i = 0; i < 4; i++) x[i] = $urandom;
    exp_out = ref_dec(32, 20, k32, x[0], x[1], x[2], x[3]);
    accept_block(x[0], x[1], x[2], x[3], 1'b0);
    c1 = acc_cyc;
    for (int i = 0; i < 4; i++) x[i] = $urandom;
    exp2 = ref_dec(32, 20, k32, x[0], x[1], x[2], x[3]);
    ia = x[0]; ib = x[1]; ic = x[2]; id = x[3];
    wait_out(22, exp_out);
    accept_block(x[0], x[1], x[2], x[3], 1'b1);
    chk("b2b_gap", (acc_cyc - c1) == 23, acc_cyc - c1, 23);
    wait_out(22, exp2);

    // Reset while rounds are in flight.
    for (int i = 0; i < 4; i++) x[i] = $urandom;
    accept_block(x[0], x[1], x[2], x[3], 1'b1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    exp_out = '0;
    chk("midrst_out_valid", cur_valid === 1'b0, cur_valid, 1'b0);
    chk("midrst_busy", cur_busy === 1'b0, cur_busy, 1'b0);
    chk("midrst_outputs", cur_out === exp_out, cur_out, exp_out);
    chk("midrst_in_ready", cur_ready === 1'b1, cur_ready, 1'b1);
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_no_result", cur_valid === 1'b0, cur_valid, 1'b0);
    accept_block(32'h36a5c38f, 32'h78f7b156, 32'h4edf29c1, 32'h1ea44898, 1'b1);
    wait_out(22, exp_out);

    // Random blocks under the zero-key table.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) x[i] = $urandom;
      exp_out = ref_dec(32, 20, k32, x[0], x[1], x[2], x[3]);
      accept_block(x[0], x[1], x[2], x[3], 1'b1);
      wait_out(22, exp_out);
    end
    tick();

    // Small configuration: fresh random keys and blocks each time.
    sel = 1'b1;
    #1;
    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < 12; j++) k16[j] = 64'($urandom_range(0, 65535));
      pack_keys();
      for (int i = 0; i < 4; i++) x[i] = 32'($urandom_range(0, 65535));
      exp_out = ref_dec(16, 4, k16, x[0], x[1], x[2], x[3]);
      accept_block(x[0], x[1], x[2], x[3], 1'b1);
      wait_out(6, exp_out);
    end
    tick();

`ifdef RC6_ENC_EN
    sel = 1'b0;
    #1;
    mode = 1'b1;
    accept_block(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_out(22, {32'h36a5c38f, 32'h78f7b156, 32'h4edf29c1, 32'h1ea44898});
    mode = 1'b0;
    exp_out = '0;
    accept_block(32'h36a5c38f, 32'h78f7b156, 32'h4edf29c1, 32'h1ea44898, 1'b1);
    wait_out(22, exp_out);
    tick();
    sel = 1'b1;
    #1;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) x[i] = 32'($urandom_range(0, 65535));
      exp_out = ref_enc(16, 4, k16, x[0], x[1], x[2], x[3]);
      mode = 1'b1;
      accept_block(x[0], x[1], x[2], x[3], 1'b1);
      mode = 1'b0;
      wait_out(6, exp_out);
    end
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc6_decrypt_core.md
# rc6_decrypt_core

Iterative, parametrised RC6 block-decryption engine: accepts one four-word ciphertext block over a valid/ready handshake, runs R decryption rounds at one round per clock, and returns the plaintext over a second valid/ready handshake. Round keys come from an external key-schedule block as one flat bus. It sits between the cipher datapath input buffer and the plaintext output stage. An optional compile-time encrypt mode lets one instance serve both directions.

## Interface
- W, 32, word size in bits; power of two, 8..64; LGW = $clog2(W)
- R, 20, number of rounds; 1..255
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input block present
- in_ready  out  1  core can accept a block (high only in IDLE)
- in_a, in_b, in_c, in_d  in  W each  ciphertext words A..D
- key_s  in  (2R+4)*W  round keys; S[j] = key_s[j*W +: W]; must hold stable from accept until output accepted
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_a, out_b, out_c, out_d  out  W each  plaintext words A..D
- busy  out  1  high in every state except IDLE

## Operation
- Reset: state IDLE; out_a..out_d = 0, out_valid = 0, busy = 0; in_ready = 1 from the first cycle after reset.
- All arithmetic modulo 2^W; rotate amounts are the low LGW bits of the operand.
- FSM IDLE -> ROUND -> POST -> DONE -> IDLE.
- IDLE: on in_valid && in_ready, register A = in_a - S[2R+2], B = in_b, C = in_c - S[2R+3], D = in_d; round counter i = R; go ROUND.
- ROUND, per cycle: (A,B,C,D) <- (D,A,B,C); u = rotl(D*(2D+1), LGW); t = rotl(B*(2B+1), LGW); C = rotr(C - S[2i+1], t) ^ u; A = rotr(A - S[2i], u) ^ t (all on the rotated values). i decrements; after round i = 1, go POST.
- POST: B <- B - S[0], D <- D - S[1]; go DONE.
- DONE: out_valid = 1, outputs hold A..D; on out_ready go IDLE. Outputs keep their last value in IDLE.
- in_valid ignored outside IDLE; in_ready never high while busy.
- Reset mid-operation (any state): abort, reset values above on the next edge; no partial result emitted.
- key_s changed while busy: result undefined (not checked by the core).

## Timing
- Accept edge k; R round edges k+1..k+R; POST edge k+R+1; out_valid high from cycle k+R+2.
- Latency R+2 cycles handshake-to-out_valid.
- out_ready held high: DONE lasts one cycle, in_ready high in cycle k+R+3; minimum block period R+3 cycles.
- out_ready low: DONE and outputs hold indefinitely, stable.
- Round counter width $clog2(R+1); key mux selects S[2i], S[2i+1] combinationally from i.

## Configuration
- RC6_ENC_EN defined: adds input port mode (1 bit), sampled at the accept edge; mode=1 runs RC6 encryption on the same FSM: accept B += S[0], D += S[1]; round i = 1..R: t = rotl(B*(2B+1), LGW), u = rotl(D*(2D+1), LGW), A = rotl(A^t, u) + S[2i], C = rotl(C^u, t) + S[2i+1], (A,B,C,D) <- (B,C,D,A); POST A += S[2R+2], C += S[2R+3]. Same latency. mode=0 identical to decrypt above.
- Undefined: no mode port, decrypt only.

## Structure
- rc6_pkg: FSM state enum, rotl/rotr functions parameterised on W, key-index helpers.
- One sub-module rc6_round: combinational single round (decrypt; encrypt path under RC6_ENC_EN), inputs A..D and two round keys, outputs next A..D.

## Test plan
- Known answer: S from the all-zero 128-bit key, W=32, R=20; in (A,B,C,D) = (0x36a5c38f, 0x78f7b156, 0x4edf29c1, 0x1ea44898) -> out all zero, out_valid exactly 22 cycles after accept.
- Backpressure: same vector, out_ready low 10 cycles -> outputs/out_valid stable, in_ready low, then IDLE one cycle after out_ready.
- Back-to-back: in_valid held high with two blocks, out_ready high -> second accept exactly 23 cycles after the first.
- Reset at round 7 -> next cycle out_valid 0, busy 0, outputs 0, in_ready 1; a new block then decrypts correctly.
- Small config W=16, R=4, random S and blocks vs software model -> bit-exact, latency 6.
- RC6_ENC_EN: encrypt zero plaintext with the zero-key S (mode=1) -> 0x36a5c38f, 0x78f7b156, 0x4edf29c1, 0x1ea44898; feed back with mode=0 -> zeros.
